// File: rtl/vec_mac_engine_if.sv
// ----------------------------------------------------------------------------
// vec_mac_engine_if
//
// Purpose:
//   Bundles the command, operand-stream and result signals of vec_mac_engine
//   so that the operand fetch side and the engine share one typed connection.
//
// Signals:
//   start     1       one-cycle launch pulse
//   mode      1       0 = MAC (acc += a*b), 1 = MSUB (acc -= a*b)
//   n         CNT_W   number of operand pairs
//   c_in      ACC_W   signed initial accumulator value
//   abort     1       synchronous cancel
//   in_valid  1       operand pair valid
//   in_ready  1       engine accepts a pair this cycle
//   a_data    DATA_W  signed operand a
//   b_data    DATA_W  signed operand b
//   busy      1       engine not idle
//   done      1       one-cycle pulse, c_out valid
//   c_out     ACC_W   signed result
//   ovf       1       sticky overflow flag
//
// Modports:
//   master  - the fetch/control side that drives commands and operands
//   slave   - the engine itself
// ----------------------------------------------------------------------------
interface vec_mac_engine_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 16
);
    logic                     start;
    logic                     mode;
    logic [CNT_W-1:0]         n;
    logic signed [ACC_W-1:0]  c_in;
    logic                     abort;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_data;
    logic signed [DATA_W-1:0] b_data;
    logic                     busy;
    logic                     done;
    logic signed [ACC_W-1:0]  c_out;
    logic                     ovf;

    modport master (
        output start, mode, n, c_in, abort, in_valid, a_data, b_data,
        input  in_ready, busy, done, c_out, ovf
    );

    modport slave (
        input  start, mode, n, c_in, abort, in_valid, a_data, b_data,
        output in_ready, busy, done, c_out, ovf
    );
endinterface

// File: rtl/vec_mac_engine.sv
// ----------------------------------------------------------------------------
// vec_mac_engine
//
// Purpose:
//   Streaming signed multiply-accumulate engine.
//   Computes c_out = c_in +/- sum(a[i]*b[i]) over n operand pairs delivered
//   on a valid/ready stream. Two-stage pipeline: a product register fed by
//   the accepted pair, then an accumulate stage that runs every cycle the
//   product register holds a valid product. Sustains one pair per cycle.
//
// Parameters:
//   DATA_W  width of signed operands a/b
//   ACC_W   width of the signed accumulator, c_in and c_out (>= 2*DATA_W)
//   CNT_W   width of the element count n
//   SAT     1 = clamp the accumulator on overflow, 0 = two's-complement wrap
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   vec_mac_engine_if.slave (command, operand stream, result, status)
//
// Latency:
//   last pair accepted at edge k -> final accumulate at edge k+1 ->
//   DONE entered (done=1, c_out updated) at edge k+2.
//   n == 0 goes straight to DONE on the start edge with c_out = c_in.
// ----------------------------------------------------------------------------
module vec_mac_engine #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 16,
    parameter bit SAT    = 1'b0
) (
    input logic             clk,
    input logic             rst,
    vec_mac_engine_if.slave bus
);

    localparam int PROD_W = 2 * DATA_W;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  n_q;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [PROD_W-1:0] prod;
    logic              p_vld;
    logic [ACC_W-1:0]  c_out_q;
    logic              ovf_q;

    // ------------------------------------------------------------------------
    // Handshake and counting
    // ------------------------------------------------------------------------
    logic             accept;
    logic             last_pair;
    logic [CNT_W-1:0] cnt_inc;

    // abort wins over acceptance: a pair offered in the abort cycle is dropped.
    assign accept    = (state == RUN) && bus.in_valid && !bus.abort;
    assign cnt_inc   = cnt + 1'b1;
    assign last_pair = accept && (cnt_inc == n_q);

    // ------------------------------------------------------------------------
    // Multiply stage: full-width signed product. Sign-extending both operands
    // to PROD_W and keeping the low PROD_W bits of the product gives the
    // exact signed result without relying on expression signedness rules.
    // ------------------------------------------------------------------------
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] mul;

    assign a_ext = {{DATA_W{bus.a_data[DATA_W-1]}}, bus.a_data};
    assign b_ext = {{DATA_W{bus.b_data[DATA_W-1]}}, bus.b_data};
    assign mul   = a_ext * b_ext;

    // ------------------------------------------------------------------------
    // Accumulate stage. The sum is formed one bit wider than the accumulator;
    // overflow is exactly the case where the top two bits of that sum differ,
    // and the top bit then carries the true sign used to pick the clamp rail.
    // ------------------------------------------------------------------------
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_upd;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_ext  = {acc[ACC_W-1], acc};
        prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        sum      = mode_q ? (acc_ext - prod_ext) : (acc_ext + prod_ext);
        sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        acc_upd  = sum[ACC_W-1:0];
        if (SAT && sum_ovf) begin
            acc_upd = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // ------------------------------------------------------------------------
    // Controller: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_pair) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The final product is folded in on the first DRAIN edge;
                // once p_vld has cleared, acc holds the finished result.
                if (!p_vld) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (bus.abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q     <= '0;
            mode_q  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            prod    <= '0;
            p_vld   <= 1'b0;
            c_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // Product stage. p_vld follows acceptance, which also clears it
            // on abort and in every non-RUN state.
            p_vld <= accept;
            if (accept) begin
                prod <= mul;
                cnt  <= cnt_inc;
            end

            // Command latch (IDLE only) or accumulate. A start in any other
            // state is ignored, so the latched operation is never disturbed.
            if ((state == IDLE) && bus.start) begin
                n_q    <= bus.n;
                mode_q <= bus.mode;
                acc    <= bus.c_in;
                ovf_q  <= 1'b0;
                cnt    <= '0;
            end else if (p_vld && !bus.abort) begin
                acc <= acc_upd;
                if (sum_ovf) begin
                    ovf_q <= 1'b1;
                end
            end

            // Result register loads only on entry to DONE. The zero-length
            // case enters DONE straight from IDLE, where acc is not yet
            // loaded, so c_in is taken directly.
            if ((state != DONE) && (state_next == DONE)) begin
                c_out_q <= (state == IDLE) ? bus.c_in : acc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready = (state == RUN);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.c_out    = c_out_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_vec_mac_engine.sv
// ----------------------------------------------------------------------------
// tb_vec_mac_engine
//
// Directed bench for vec_mac_engine. Two engines share one stimulus: one
// wrapping (SAT=0, the reference for most results) and one saturating
// (SAT=1, compared in the overflow cases).
// ----------------------------------------------------------------------------
module tb_vec_mac_engine;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic                     start;
    logic                     mode;
    logic [CNT_W-1:0]         n;
    logic signed [ACC_W-1:0]  c_in;
    logic                     abort;
    logic                     in_valid;
    logic signed [DATA_W-1:0] a_data;
    logic signed [DATA_W-1:0] b_data;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    vec_mac_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus_wrap ();
    vec_mac_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus_sat ();

    assign bus_wrap.start    = start;
    assign bus_wrap.mode     = mode;
    assign bus_wrap.n        = n;
    assign bus_wrap.c_in     = c_in;
    assign bus_wrap.abort    = abort;
    assign bus_wrap.in_valid = in_valid;
    assign bus_wrap.a_data   = a_data;
    assign bus_wrap.b_data   = b_data;

    assign bus_sat.start     = start;
    assign bus_sat.mode      = mode;
    assign bus_sat.n         = n;
    assign bus_sat.c_in      = c_in;
    assign bus_sat.abort     = abort;
    assign bus_sat.in_valid  = in_valid;
    assign bus_sat.a_data    = a_data;
    assign bus_sat.b_data    = b_data;

    vec_mac_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_wrap)
    );

    vec_mac_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b1)
    ) dut_sat (
        .clk(clk),
        .rst(rst),
        .bus(bus_sat)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic m, input logic [CNT_W-1:0] len,
                          input logic signed [ACC_W-1:0] init);
        start = 1'b1;
        mode  = m;
        n     = len;
        c_in  = init;
        tick();
        start = 1'b0;
    endtask

    // Offer one pair for one cycle; in_valid is left high for back-to-back use.
    task automatic push(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
        in_valid = 1'b1;
        a_data   = a;
        b_data   = b;
        tick();
    endtask

    int done_cnt;
    int done_at;
    logic [63:0] c_at_done;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        n        = '0;
        c_in     = '0;
        abort    = 1'b0;
        in_valid = 1'b0;
        a_data   = '0;
        b_data   = '0;

        // ---------------- reset ----------------
        #2 rst = 1'b0;
        #1;
        check("rst_busy",     64'(bus_wrap.busy),     64'd0);
        check("rst_in_ready", 64'(bus_wrap.in_ready), 64'd0);
        check("rst_done",     64'(bus_wrap.done),     64'd0);
        check("rst_c_out",    bus_wrap.c_out,         64'd0);
        check("rst_ovf",      64'(bus_wrap.ovf),      64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ---------------- basic MAC: 10 + 6 + 20 - 7 = 29 ----------------
        launch(1'b0, 16'd3, 64'sd10);
        check("mac_busy",     64'(bus_wrap.busy),     64'd1);
        check("mac_ready",    64'(bus_wrap.in_ready), 64'd1);
        push(32'sd2, 32'sd3);
        push(32'sd4, 32'sd5);
        push(-32'sd1, 32'sd7);
        in_valid = 1'b0;
        check("mac_ready_low", 64'(bus_wrap.in_ready), 64'd0);
        check("mac_done_k0",   64'(bus_wrap.done),     64'd0);
        tick();
        check("mac_done_k1",   64'(bus_wrap.done),     64'd0);
        tick();
        check("mac_done_k2",   64'(bus_wrap.done),     64'd1);
        check("mac_c_out",     bus_wrap.c_out,         64'd29);
        check("mac_ovf",       64'(bus_wrap.ovf),      64'd0);
        tick();
        check("mac_done_drop", 64'(bus_wrap.done),     64'd0);
        check("mac_idle",      64'(bus_wrap.busy),     64'd0);
        check("mac_c_hold",    bus_wrap.c_out,         64'd29);

        // ---------------- MSUB with gaps: 100 - 42 + 12 = 70 ----------------
        launch(1'b1, 16'd2, 64'sd100);
        push(32'sd6, 32'sd7);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("msub_gap_busy",  64'(bus_wrap.busy),     64'd1);
            check("msub_gap_ready", 64'(bus_wrap.in_ready), 64'd1);
            check("msub_gap_done",  64'(bus_wrap.done),     64'd0);
        end
        push(32'sd3, -32'sd4);
        in_valid  = 1'b0;
        done_cnt  = 0;
        done_at   = -1;
        c_at_done = '0;
        for (int i = 1; i <= 6; i++) begin
            if (bus_wrap.done) begin
                done_cnt++;
                done_at   = i - 1;
                c_at_done = bus_wrap.c_out;
            end
            tick();
        end
        check("msub_done_count", 64'(done_cnt),  64'd1);
        check("msub_done_at",    64'(done_at),   64'd2);
        check("msub_c_out",      c_at_done,      64'd70);

        // ---------------- zero length ----------------
        in_valid = 1'b1;
        a_data   = 32'sd9;
        b_data   = 32'sd9;
        launch(1'b0, 16'd0, -64'sd5);
        check("zero_done",   64'(bus_wrap.done),     64'd1);
        check("zero_c_out",  bus_wrap.c_out,         64'hFFFF_FFFF_FFFF_FFFB);
        check("zero_ready",  64'(bus_wrap.in_ready), 64'd0);
        tick();
        check("zero_done_drop", 64'(bus_wrap.done),     64'd0);
        check("zero_ready2",    64'(bus_wrap.in_ready), 64'd0);
        in_valid = 1'b0;

        // ---------------- positive overflow ----------------
        launch(1'b0, 16'd1, 64'sh7FFF_FFFF_FFFF_FFF0);
        push(32'sd4, 32'sd5);
        in_valid = 1'b0;
        tick();
        tick();
        check("ovfp_done",       64'(bus_wrap.done), 64'd1);
        check("ovfp_wrap_c_out", bus_wrap.c_out,     64'h8000_0000_0000_0004);
        check("ovfp_wrap_ovf",   64'(bus_wrap.ovf),  64'd1);
        check("ovfp_sat_c_out",  bus_sat.c_out,      64'h7FFF_FFFF_FFFF_FFFF);
        check("ovfp_sat_ovf",    64'(bus_sat.ovf),   64'd1);
        tick();

        // ---------------- negative overflow (MSUB) ----------------
        launch(1'b1, 16'd1, 64'sh8000_0000_0000_0005);
        check("ovfn_ovf_clr",    64'(bus_wrap.ovf),  64'd0);
        push(32'sd2, 32'sd5);
        in_valid = 1'b0;
        tick();
        tick();
        check("ovfn_wrap_c_out", bus_wrap.c_out,     64'h7FFF_FFFF_FFFF_FFFB);
        check("ovfn_wrap_ovf",   64'(bus_wrap.ovf),  64'd1);
        check("ovfn_sat_c_out",  bus_sat.c_out,      64'h8000_0000_0000_0000);
        check("ovfn_sat_ovf",    64'(bus_sat.ovf),   64'd1);
        tick();
        check("ovfn_ovf_hold",   64'(bus_wrap.ovf),  64'd1);

        // ---------------- abort after two acceptances ----------------
        launch(1'b0, 16'd4, 64'sd1);
        push(32'sd1, 32'sd1);
        push(32'sd1, 32'sd1);
        abort    = 1'b1;
        in_valid = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy",  64'(bus_wrap.busy),     64'd0);
        check("abort_ready", 64'(bus_wrap.in_ready), 64'd0);
        check("abort_c_out", bus_wrap.c_out,         64'h7FFF_FFFF_FFFF_FFFB);
        check("abort_ovf",   64'(bus_wrap.ovf),      64'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_wrap.done) done_cnt++;
            tick();
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // ---------------- start during RUN is ignored: 25 + 6 = 31 ----------------
        launch(1'b0, 16'd2, 64'sd0);
        start = 1'b1;
        mode  = 1'b1;
        n     = 16'd5;
        c_in  = 64'sd1000;
        push(32'sd5, 32'sd5);
        start = 1'b0;
        push(32'sd2, 32'sd3);
        in_valid = 1'b0;
        check("ign_ready_low", 64'(bus_wrap.in_ready), 64'd0);
        tick();
        tick();
        check("ign_done",  64'(bus_wrap.done), 64'd1);
        check("ign_c_out", bus_wrap.c_out,     64'd31);
        tick();

        // ---------------- async reset mid-RUN ----------------
        launch(1'b0, 16'd3, 64'sd50);
        push(32'sd1, 32'sd1);
        #3 rst = 1'b0;
        #1;
        check("arst_busy",  64'(bus_wrap.busy),     64'd0);
        check("arst_ready", 64'(bus_wrap.in_ready), 64'd0);
        check("arst_done",  64'(bus_wrap.done),     64'd0);
        check("arst_c_out", bus_wrap.c_out,         64'd0);
        check("arst_ovf",   64'(bus_wrap.ovf),      64'd0);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("arst_idle", 64'(bus_wrap.busy), 64'd0);
        launch(1'b0, 16'd1, 64'sd0);
        push(32'sd3, 32'sd3);
        in_valid = 1'b0;
        tick();
        tick();
        check("post_rst_done",  64'(bus_wrap.done), 64'd1);
        check("post_rst_c_out", bus_wrap.c_out,     64'd9);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
